// File: rtl/btb_nway.sv
// btb_nway: N-way set-associative branch target buffer with tree PLRU replacement and a row-sweep flush
module btb_nway #(
  parameter int VLEN    = 64,
  parameter int NR_ROWS = 128,
  parameter int WAYS    = 4,
  parameter int OFFSET  = 1,
  parameter int TYPE_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              vpc_valid_i,
  input  logic [VLEN-1:0]   vpc_i,
  output logic              pred_valid_o,
  output logic              pred_hit_o,
  output logic [VLEN-1:0]   pred_target_o,
  output logic [TYPE_W-1:0] pred_type_o,
  input  logic              upd_valid_i,
  input  logic              upd_kill_i,
  input  logic [VLEN-1:0]   upd_pc_i,
  input  logic [VLEN-1:0]   upd_target_i,
  input  logic [TYPE_W-1:0] upd_type_i,
  output logic              busy_o
);
  localparam int ROW_W = $clog2(NR_ROWS);
  localparam int LW    = $clog2(WAYS);
  localparam int TAG_W = VLEN - OFFSET - ROW_W;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state;
  logic [ROW_W-1:0]  cnt;
  logic [WAYS-1:0]   valid [NR_ROWS];
  logic [WAYS-2:0]   plru  [NR_ROWS];
  logic [TAG_W-1:0]  tags  [NR_ROWS][WAYS];
  logic [VLEN-1:0]   tgts  [NR_ROWS][WAYS];
  logic [TYPE_W-1:0] types [NR_ROWS][WAYS];

  logic [ROW_W-1:0] l_row, u_row;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, u_free, lk_hit, up_en, wr, kl, busy;
  logic [LW-1:0]    l_way, u_way, u_fway, u_wway;
  logic             unused_bits;

  // Walk root to leaf, pointing each node on the path away from the touched way
  function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] p, input logic [LW-1:0] w);
    int n = 0;
    for (int l = LW-1; l >= 0; l--) begin
      p[n] = ~w[l];
      n = 2*n + (w[l] ? 2 : 1);
    end
    return p;
  endfunction

  function automatic logic [LW-1:0] victim(input logic [WAYS-2:0] p);
    logic [LW-1:0] v = '0;
    int n = 0;
    for (int l = LW-1; l >= 0; l--) begin
      v[l] = p[n];
      n = 2*n + (p[n] ? 2 : 1);
    end
    return v;
  endfunction

  assign l_row       = vpc_i[OFFSET+ROW_W-1:OFFSET];
  assign l_tag       = vpc_i[VLEN-1:OFFSET+ROW_W];
  assign u_row       = upd_pc_i[OFFSET+ROW_W-1:OFFSET];
  assign u_tag       = upd_pc_i[VLEN-1:OFFSET+ROW_W];
  assign unused_bits = ^{vpc_i[OFFSET-1:0], upd_pc_i[OFFSET-1:0]};
  assign busy        = state == FLUSH;
  assign busy_o      = busy;
  assign lk_hit      = vpc_valid_i && !busy && l_hit;
  assign up_en       = upd_valid_i && !busy && !flush_i;
  assign wr          = up_en && !upd_kill_i;
  assign kl          = up_en && upd_kill_i && u_hit;
  assign u_wway      = u_hit ? u_way : u_free ? u_fway : victim(plru[u_row]);

  // Descending scans so the lowest matching or free way wins
  always_comb begin
    l_hit  = 1'b0;
    l_way  = '0;
    u_hit  = 1'b0;
    u_way  = '0;
    u_free = 1'b0;
    u_fway = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid[l_row][w] && tags[l_row][w] == l_tag) begin
        l_hit = 1'b1;
        l_way = LW'(w);
      end
      if (valid[u_row][w] && tags[u_row][w] == u_tag) begin
        u_hit = 1'b1;
        u_way = LW'(w);
      end
      if (!valid[u_row][w]) begin
        u_free = 1'b1;
        u_fway = LW'(w);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush_i) begin
      state <= FLUSH;
      cnt   <= '0;
    end else if (busy) begin
      state <= cnt == ROW_W'(NR_ROWS-1) ? IDLE : FLUSH;
      cnt   <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NR_ROWS; r++) begin
        valid[r] <= '0;
        plru[r]  <= '0;
      end
    end else begin
      if (lk_hit && !(up_en && u_row == l_row))
        plru[l_row] <= touch(plru[l_row], l_way);
      if (wr) begin
        valid[u_row][u_wway] <= 1'b1;
        plru[u_row]          <= touch(plru[u_row], u_wway);
      end
      if (kl)
        valid[u_row][u_way] <= 1'b0;
      if (busy) begin
        valid[cnt] <= '0;
        plru[cnt]  <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) begin
      tags[u_row][u_wway]  <= u_tag;
      tgts[u_row][u_wway]  <= upd_target_i;
      types[u_row][u_wway] <= upd_type_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_valid_o  <= 1'b0;
      pred_hit_o    <= 1'b0;
      pred_target_o <= '0;
      pred_type_o   <= '0;
    end else begin
      pred_valid_o  <= vpc_valid_i;
      pred_hit_o    <= lk_hit;
      pred_target_o <= lk_hit ? tgts[l_row][l_way] : '0;
      pred_type_o   <= lk_hit ? types[l_row][l_way] : '0;
    end
  end
endmodule

// File: tb/tb_btb_nway.sv
// tb_btb_nway: directed checks of lookup, update, PLRU eviction, kill, flush sweep and reset
module tb_btb_nway;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        vpc_valid_i = 1'b0;
  logic [63:0] vpc_i = '0;
  logic        pred_valid_o, pred_hit_o, busy_o;
  logic [63:0] pred_target_o;
  logic [1:0]  pred_type_o;
  logic        upd_valid_i = 1'b0;
  logic        upd_kill_i = 1'b0;
  logic [63:0] upd_pc_i = '0;
  logic [63:0] upd_target_i = '0;
  logic [1:0]  upd_type_i = '0;
  int          checks = 0;
  int          errors = 0;
  int          n;
  logic        any_hit;

  btb_nway dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .vpc_valid_i(vpc_valid_i), .vpc_i(vpc_i),
    .pred_valid_o(pred_valid_o), .pred_hit_o(pred_hit_o),
    .pred_target_o(pred_target_o), .pred_type_o(pred_type_o),
    .upd_valid_i(upd_valid_i), .upd_kill_i(upd_kill_i), .upd_pc_i(upd_pc_i),
    .upd_target_i(upd_target_i), .upd_type_i(upd_type_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [63:0] pc, input logic h, input logic [63:0] t,
                        input logic [1:0] ty, input string tag);
    vpc_valid_i = 1'b1;
    vpc_i = pc;
    tick;
    vpc_valid_i = 1'b0;
    chk({tag, "_valid"}, 64'(pred_valid_o), 64'd1);
    chk({tag, "_hit"}, 64'(pred_hit_o), 64'(h));
    chk({tag, "_target"}, pred_target_o, t);
    chk({tag, "_type"}, 64'(pred_type_o), 64'(ty));
  endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] t, input logic [1:0] ty, input logic kill);
    upd_valid_i = 1'b1;
    upd_kill_i = kill;
    upd_pc_i = pc;
    upd_target_i = t;
    upd_type_i = ty;
    tick;
    upd_valid_i = 1'b0;
    upd_kill_i = 1'b0;
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    tick;
    tick;
    rst_i = 1'b0;
  endtask

  task automatic populate;
    upd(64'h1000, 64'h2000, 2'd1, 1'b0);
    upd(64'h1100, 64'h2100, 2'd2, 1'b0);
    upd(64'h1200, 64'h2200, 2'd3, 1'b0);
    upd(64'h1300, 64'h2300, 2'd0, 1'b0);
  endtask

  initial begin
    tick;
    chk("rst_valid", 64'(pred_valid_o), 64'd0);
    chk("rst_hit", 64'(pred_hit_o), 64'd0);
    chk("rst_target", pred_target_o, 64'd0);
    chk("rst_type", 64'(pred_type_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    rst_i = 1'b0;
    tick;
    lookup(64'h1000, 1'b0, 64'd0, 2'd0, "empty");

    // Update and lookup of the same PC together: lookup sees the old state
    upd_valid_i = 1'b1; upd_pc_i = 64'h1000; upd_target_i = 64'h2000; upd_type_i = 2'd1;
    vpc_valid_i = 1'b1; vpc_i = 64'h1000;
    tick;
    upd_valid_i = 1'b0; vpc_valid_i = 1'b0;
    chk("same_cycle_hit", 64'(pred_hit_o), 64'd0);
    chk("same_cycle_target", pred_target_o, 64'd0);
    lookup(64'h1000, 1'b1, 64'h2000, 2'd1, "after_upd");
    tick;
    chk("idle_valid", 64'(pred_valid_o), 64'd0);
    chk("idle_target", pred_target_o, 64'd0);

    do_reset;
    populate;
    lookup(64'h1000, 1'b1, 64'h2000, 2'd1, "plru_touch");
    upd(64'h1400, 64'h2400, 2'd1, 1'b0);
    lookup(64'h1000, 1'b1, 64'h2000, 2'd1, "evict_1000");
    lookup(64'h1100, 1'b1, 64'h2100, 2'd2, "evict_1100");
    lookup(64'h1300, 1'b1, 64'h2300, 2'd0, "evict_1300");
    lookup(64'h1400, 1'b1, 64'h2400, 2'd1, "evict_1400");
    lookup(64'h1200, 1'b0, 64'd0, 2'd0, "evict_1200");

    upd(64'h1000, 64'h0, 2'd0, 1'b1);
    lookup(64'h1000, 1'b0, 64'd0, 2'd0, "kill_1000");
    upd(64'h3000, 64'h0, 2'd0, 1'b1);
    lookup(64'h1100, 1'b1, 64'h2100, 2'd2, "killabs_1100");
    lookup(64'h1300, 1'b1, 64'h2300, 2'd0, "killabs_1300");
    lookup(64'h1400, 1'b1, 64'h2400, 2'd1, "killabs_1400");
    upd(64'h1000, 64'h2abc, 2'd3, 1'b0);
    lookup(64'h1000, 1'b1, 64'h2abc, 2'd3, "reuse_1000");
    lookup(64'h1100, 1'b1, 64'h2100, 2'd2, "reuse_1100");
    lookup(64'h1300, 1'b1, 64'h2300, 2'd0, "reuse_1300");
    lookup(64'h1400, 1'b1, 64'h2400, 2'd1, "reuse_1400");

    // Single flush pulse with an update and lookups issued during the sweep
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    n = 0;
    any_hit = 1'b0;
    vpc_valid_i = 1'b1;
    vpc_i = 64'h1100;
    while (busy_o && n < 400) begin
      upd_valid_i = n == 5;
      upd_pc_i = 64'h5000;
      upd_target_i = 64'h6000;
      upd_type_i = 2'd1;
      n++;
      tick;
      any_hit = any_hit | pred_hit_o;
    end
    upd_valid_i = 1'b0;
    vpc_valid_i = 1'b0;
    chk("flush_busy_len", 64'(n), 64'd128);
    chk("flush_busy_hit", 64'(any_hit), 64'd0);
    lookup(64'h1000, 1'b0, 64'd0, 2'd0, "post_flush_1000");
    lookup(64'h1100, 1'b0, 64'd0, 2'd0, "post_flush_1100");
    lookup(64'h1400, 1'b0, 64'd0, 2'd0, "post_flush_1400");
    lookup(64'h5000, 1'b0, 64'd0, 2'd0, "post_flush_5000");

    // Re-pulse so that flush_i is sampled after 60 busy cycles
    upd(64'h1000, 64'h2000, 2'd1, 1'b0);
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    n = 0;
    while (busy_o && n < 400) begin
      flush_i = n == 59;
      n++;
      tick;
    end
    flush_i = 1'b0;
    chk("reflush_busy_len", 64'(n), 64'd188);
    lookup(64'h1000, 1'b0, 64'd0, 2'd0, "post_reflush");

    // Asynchronous reset in the middle of a sweep
    upd(64'h1000, 64'h2000, 2'd1, 1'b0);
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    vpc_valid_i = 1'b1;
    vpc_i = 64'h1000;
    for (int i = 0; i < 50; i++) tick;
    chk("midflush_busy_pre", 64'(busy_o), 64'd1);
    chk("midflush_valid_pre", 64'(pred_valid_o), 64'd1);
    rst_i = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_valid", 64'(pred_valid_o), 64'd0);
    chk("midrst_hit", 64'(pred_hit_o), 64'd0);
    chk("midrst_target", pred_target_o, 64'd0);
    vpc_valid_i = 1'b0;
    tick;
    rst_i = 1'b0;
    lookup(64'h1000, 1'b0, 64'd0, 2'd0, "post_midrst");
    chk("post_midrst_busy", 64'(busy_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
